pim_matmul_memory: RTL and testbench
====================================

# pim_matmul_memory

Processing-in-memory matrix-multiply block: a word-addressed memory array with a built-in 8×8 matrix-multiply engine. A `start` rising edge launches `C = A × B`. A, B and C are row-major 8×8 matrices located at `src1_addr`, `src2_addr` and `dst_addr`. The block has no data outputs; results are read back from the internal array by the surrounding system or bench.

## Interface
- `LEN`, 10 (from `types` package): address width; array depth is 2^LEN words.
- `DATA_W`, 32: word width; all arithmetic is modulo 2^DATA_W, unsigned.
- `N`, 8: matrix dimension (fixed, not a port).
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `src1_addr`  in  LEN  base word address of A.
- `src2_addr`  in  LEN  base word address of B.
- `dst_addr`  in  LEN  base word address of C.
- `start`  in  1  level input; a 0→1 transition while idle launches one operation.
- Internal, hierarchically visible to verification: array `mem[0:2^LEN-1]` of DATA_W bits, and state register `state`.

## Operation
- Element addressing:
  - A[i][k] = mem[src1 + 8i + k]
  - B[k][j] = mem[src2 + 8k + j]
  - C[i][j] → mem[dst + 8i + j]
  - All address sums wrap modulo 2^LEN.
- Reset (asynchronous, `rst`=1):
  - every mem[a] = a mod 8, zero-extended;
  - `state`=IDLE; counters i, j, k = 0; accumulator = 0; result buffer = 0; start_q = 0.
- Start detect: registered `start_q`. Launch when state==IDLE && start && !start_q.
  - `start` already high when reset releases counts as an edge.
  - `start` held high after completion does not relaunch; it must drop for at least one cycle first.
  - `start` edges seen while busy are ignored.
- On launch, latch `src1_addr`, `src2_addr`, `dst_addr`. Later changes to these ports have no effect on the running operation.
- FSM:
  - IDLE → COMPUTE on launch.
  - COMPUTE: one MAC per cycle, k innermost, then j, then i. acc += A[i][k]·B[k][j], using two combinational array reads. When k==7, write acc + product into result buffer entry 8i+j and clear acc. After (i,j,k) = (7,7,7), go to WRITEBACK.
  - WRITEBACK: one word per cycle, buffer[n] → mem[dst + n] for n = 0..63. After n = 63, go to IDLE.
- Operand isolation: every operand read completes before any destination write. Results are therefore correct even when dst overlaps src1 or src2.
- No other words of mem are modified by an operation.

## Timing
- Launch edge = cycle 0.
- COMPUTE occupies cycles 1–512.
- WRITEBACK occupies cycles 513–576; mem[dst + n] is updated at the edge ending cycle 513 + n.
- IDLE from cycle 577. The earliest relaunch edge is the first cycle in IDLE with start && !start_q.
- Reset mid-operation aborts immediately:
  - the array is re-initialised to the reset pattern;
  - no partial results survive;
  - a new start edge is required after release.
- Product and accumulation are truncated to DATA_W bits on every step.

## Test plan
- Reset with start=1, src1=100, src2=200, dst=300:
  - Required after 577 cycles: mem[300+8i+j] = 28·j, e.g. mem[300]=0, mem[301]=28, mem[307]=196, mem[363]=196.
  - Neighbours unchanged: mem[299]=3, mem[364]=4.
- After the first test, hold start=1 for 2000 more cycles → no second operation; state stays IDLE and mem[301] stays 28.
- Overlap case: drop start, set src1=1, src2=20, dst=40, raise start.
  - Required: C[i][j] = 28·((4+j) mod 8), i.e. mem[40]=112, mem[43]=196, mem[44]=0, mem[47]=84, mem[103]=84.
  - Region 300–363 unchanged.
- Wrap-around: src1=0, src2=0, dst=1020 (LEN=10) → mem[1020..1023] = 0, 28, 56, 84 and mem[0..59] hold the remaining C row-major (mem[0]=112, mem[59]=196).
- Reset asserted at cycle 300 of an operation → all mem[a] = a mod 8 and state=IDLE. With start held high across release, exactly one fresh operation runs, giving the same result as the first test.
- Change src/dst ports at cycle 10 of an operation → result matches the addresses latched at launch.

Source files
------------

// File: rtl/pim_matmul_memory.sv
// pim_matmul_memory: word-addressed memory array with an embedded 8x8
// matrix-multiply engine. A rising edge on start (while idle) computes
// C = A x B over row-major matrices held in the array itself.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (re-initialises the array)
//   src1_addr  base word address of A
//   src2_addr  base word address of B
//   dst_addr   base word address of C
//   start      level input; a 0->1 transition while idle launches one multiply
// No data outputs: results are read from mem by the surrounding system.

package types;
    localparam int LEN = 10;
    typedef enum logic [1:0] {IDLE, COMPUTE, WRITEBACK} state_t;
endpackage

module pim_matmul_memory
    import types::*;
#(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LEN-1:0] src1_addr,
    input  logic [LEN-1:0] src2_addr,
    input  logic [LEN-1:0] dst_addr,
    input  logic           start
);
    localparam int DEPTH = 1 << LEN;
    localparam int N     = 8;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    state_t            state, state_next;

    logic              start_q;
    logic [2:0]        i, j, k;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] res_buf [0:N*N-1];
    logic [LEN-1:0]    src1_r, src2_r, dst_r;

    logic              launch, last_mac, last_wb;
    logic [LEN-1:0]    a_addr, b_addr, w_addr;
    logic [DATA_W-1:0] op_a, op_b, prod, sum;

    assign launch   = (state == IDLE) && start && !start_q;
    assign last_mac = (state == COMPUTE) && ({i, j, k} == 9'h1ff);
    // During writeback {i,j} doubles as the 6-bit word index n = 8i+j.
    assign last_wb  = (state == WRITEBACK) && ({i, j} == 6'h3f);

    // Address sums wrap naturally at LEN bits.
    assign a_addr = src1_r + LEN'({i, k});
    assign b_addr = src2_r + LEN'({k, j});
    assign w_addr = dst_r  + LEN'({i, j});

    assign op_a = mem[a_addr];
    assign op_b = mem[b_addr];
    assign prod = op_a * op_b;
    assign sum  = acc + prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (launch)   state_next = COMPUTE;
            COMPUTE:   if (last_mac) state_next = WRITEBACK;
            WRITEBACK: if (last_wb)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Results are staged in res_buf and only copied to mem once every
    // operand read is done, so dst may overlap either source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= DATA_W'(a % N);
            for (int n = 0; n < N*N; n++)   res_buf[n] <= '0;
            start_q <= 1'b0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            acc     <= '0;
            src1_r  <= '0;
            src2_r  <= '0;
            dst_r   <= '0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: begin
                    if (launch) begin
                        src1_r <= src1_addr;
                        src2_r <= src2_addr;
                        dst_r  <= dst_addr;
                    end
                end
                COMPUTE: begin
                    if (k == 3'd7) begin
                        res_buf[{i, j}] <= sum;
                        acc             <= '0;
                    end else begin
                        acc <= sum;
                    end
                    // Wraps to zero after (7,7,7), ready for writeback.
                    {i, j, k} <= {i, j, k} + 9'd1;
                end
                WRITEBACK: begin
                    mem[w_addr] <= res_buf[{i, j}];
                    {i, j}      <= {i, j} + 6'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pim_matmul_memory.sv
module tb_pim_matmul_memory;
    import types::*;

    localparam int DEPTH = 1 << LEN;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [LEN-1:0] src1_addr, src2_addr, dst_addr;

    always #5 clk = ~clk;

    pim_matmul_memory #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .src1_addr (src1_addr),
        .src2_addr (src2_addr),
        .dst_addr  (dst_addr),
        .start     (start)
    );

    typedef struct packed {
        logic [LEN-1:0]    dst;
        logic [63:0][31:0] c;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [0:DEPTH-1];
    int          checks = 0, errors = 0, cyc = 0, ops_done = 0, n_expect = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = 32'(a % 8);
    endfunction

    // Reference: read all operands from the current image, then write C.
    function automatic void model_op(input int s1, input int s2, input int d);
        exp_t        e;
        logic [31:0] s;
        e.dst = LEN'(d);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                s = 0;
                for (int k = 0; k < 8; k++)
                    s = s + ref_mem[(s1 + 8*i + k) % DEPTH] * ref_mem[(s2 + 8*k + j) % DEPTH];
                e.c[8*i + j] = s;
            end
        for (int n = 0; n < 64; n++) ref_mem[(d + n) % DEPTH] = e.c[n];
        exp_q.push_back(e);
    endfunction

    function automatic void check_pattern(input string name);
        int bad = 0, first = -1;
        for (int a = 0; a < DEPTH; a++)
            if (dut.mem[a] !== 32'(a % 8)) begin
                bad++;
                if (first < 0) first = a;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d words differ, mem[%0d]=%0d expected %0d",
                     name, bad, first, dut.mem[first], first % 8);
        end
    endfunction

    // Monitor: on every completed operation pop the expected result and compare.
    initial begin
        state_t prev;
        int     t_launch, bad, first;
        exp_t   e;
        prev = IDLE;
        t_launch = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = IDLE;
            end else begin
                if (prev == IDLE && dut.state == COMPUTE) t_launch = cyc;
                if (prev == WRITEBACK && dut.state == IDLE) begin
                    check("op_duration", 32'(cyc - t_launch), 32'd576);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_op: operation completed with nothing expected");
                    end else begin
                        e = exp_q.pop_front();
                        bad = 0; first = -1;
                        for (int n = 0; n < 64; n++)
                            if (dut.mem[(int'(e.dst) + n) % DEPTH] !== e.c[n]) begin
                                bad++;
                                if (first < 0) first = n;
                            end
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("FAIL c_region: dst=%0d n=%0d got %0d expected %0d (%0d bad)",
                                     e.dst, first, dut.mem[(int'(e.dst) + first) % DEPTH], e.c[first], bad);
                        end
                        bad = 0; first = -1;
                        for (int a = 0; a < DEPTH; a++)
                            if (dut.mem[a] !== ref_mem[a]) begin
                                bad++;
                                if (first < 0) first = a;
                            end
                        checks++;
                        if (bad != 0) begin
                            errors++;
                            $display("FAIL mem_image: mem[%0d] got %0d expected %0d (%0d bad)",
                                     first, dut.mem[first], ref_mem[first], bad);
                        end
                    end
                    ops_done++;
                end
                prev = dut.state;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input int s1, input int s2, input int d);
        start = 1'b0;
        tick(1);
        src1_addr = LEN'(s1);
        src2_addr = LEN'(s2);
        dst_addr  = LEN'(d);
        start     = 1'b1;
        model_op(s1, s2, d);
        n_expect = ops_done + 1;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 1200 && ops_done < n_expect; t++) tick(1);
        check("op_done", 32'(ops_done >= n_expect), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, r1, r2, r3;

        // Start already high at reset release counts as a launch.
        rst = 1'b1; start = 1'b1;
        src1_addr = 10'd100; src2_addr = 10'd200; dst_addr = 10'd300;
        model_reset();
        model_op(100, 200, 300);
        n_expect = 1;
        tick(2);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        check_pattern("reset_pattern");
        rst = 1'b0;
        wait_done();
        check("t1_mem300", dut.mem[300], 32'd0);
        check("t1_mem301", dut.mem[301], 32'd28);
        check("t1_mem307", dut.mem[307], 32'd196);
        check("t1_mem363", dut.mem[363], 32'd196);
        check("t1_mem299", dut.mem[299], 32'd3);
        check("t1_mem364", dut.mem[364], 32'd4);

        // Start held high: no relaunch.
        bad = 0;
        for (int t = 0; t < 2000; t++) begin
            tick(1);
            if (dut.state != IDLE) bad++;
        end
        check("hold_no_relaunch", 32'(bad), 32'd0);
        check("hold_ops", 32'(ops_done), 32'd1);
        check("hold_mem301", dut.mem[301], 32'd28);

        // Destination overlapping both sources.
        launch(1, 20, 40);
        wait_done();
        check("ov_mem40", dut.mem[40], 32'd112);
        check("ov_mem43", dut.mem[43], 32'd196);
        check("ov_mem44", dut.mem[44], 32'd0);
        check("ov_mem47", dut.mem[47], 32'd84);
        check("ov_mem103", dut.mem[103], 32'd84);
        bad = 0;
        for (int n = 0; n < 64; n++) if (dut.mem[300 + n] !== 32'(28 * (n % 8))) bad++;
        check("ov_region300", 32'(bad), 32'd0);

        // Wrap-around from a fresh array.
        rst = 1'b1; start = 1'b0;
        exp_q.delete();
        model_reset();
        tick(2);
        rst = 1'b0;
        tick(1);
        launch(0, 0, 1020);
        wait_done();
        check("wr_mem1020", dut.mem[1020], 32'd0);
        check("wr_mem1021", dut.mem[1021], 32'd28);
        check("wr_mem1022", dut.mem[1022], 32'd56);
        check("wr_mem1023", dut.mem[1023], 32'd84);
        check("wr_mem0", dut.mem[0], 32'd112);
        check("wr_mem59", dut.mem[59], 32'd196);

        // Reset mid-operation, start held across release.
        launch(100, 200, 300);
        tick(300);
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        tick(2);
        check("mid_reset_state", 32'(dut.state), 32'(IDLE));
        check_pattern("mid_reset_pattern");
        model_op(100, 200, 300);
        n_expect = ops_done + 1;
        rst = 1'b0;
        wait_done();
        check("mid_mem301", dut.mem[301], 32'd28);
        check("mid_mem363", dut.mem[363], 32'd196);
        tick(700);
        check("mid_single_op", 32'(ops_done), 32'(n_expect));

        // Port changes during an operation have no effect.
        r1 = $urandom_range(0, DEPTH-1); r2 = $urandom_range(0, DEPTH-1); r3 = $urandom_range(0, DEPTH-1);
        launch(r1, r2, r3);
        tick(10);
        src1_addr = LEN'($urandom); src2_addr = LEN'($urandom); dst_addr = LEN'($urandom);
        wait_done();

        // Random operations on the evolving array contents.
        for (int t = 0; t < 6; t++) begin
            r1 = $urandom_range(0, DEPTH-1); r2 = $urandom_range(0, DEPTH-1); r3 = $urandom_range(0, DEPTH-1);
            launch(r1, r2, r3);
            wait_done();
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
